// File: rtl/fetch_pkg.sv
// Shared widths, reset default and queue entry type for the instruction fetch stage.
package fetch_pkg;
  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with registered storage, synchronous flush and occupancy count.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter type T_ENTRY = fetch_entry_t,
  parameter int  DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  T_ENTRY                 i_push_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output T_ENTRY                 o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  T_ENTRY          r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (!rst || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + PW'(1);
      if (i_pop)  r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_push_data;
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues credit-limited memory requests and queues
// returned words with their PC; redirects flush the queue and drop stale responses.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [XLEN-1:0]    instr_pc
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   r_drop_cnt;

  logic [CW-1:0]   w_inflight;
  logic [CW-1:0]   w_occ;
  logic [CW:0]     w_credit_used;
  logic            w_req_fire;
  logic            w_resp_drop;
  logic            w_q_push;
  logic            w_q_pop;
  logic [XLEN-1:0] w_tag_head;
  logic            w_tag_full;
  logic            w_tag_empty;
  logic            w_q_full;
  logic            w_q_empty;
  fetch_entry_t    w_q_in;
  fetch_entry_t    w_q_head;

  // Credit counts requests in flight plus words queued; a same-cycle pop is not credited.
  assign w_credit_used  = {1'b0, w_inflight} + {1'b0, w_occ};
  assign imem_req_valid = rst & ~redirect_valid & (w_credit_used < (CW+1)'(DEPTH))
                          & (r_drop_cnt == '0);
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid & imem_req_ready;

  assign w_resp_drop = (r_drop_cnt != '0) | redirect_valid;
  assign w_q_push    = imem_resp_valid & ~w_resp_drop;
  assign w_q_pop     = instr_valid & instr_ready;

  assign w_q_in.pc    = w_tag_head;
  assign w_q_in.instr = imem_resp_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc       <= RESET_PC;
      r_drop_cnt <= '0;
    end else if (redirect_valid) begin
      r_pc       <= align_word(redirect_pc);
      r_drop_cnt <= w_inflight - CW'(imem_resp_valid);
    end else begin
      if (w_req_fire) r_pc <= r_pc + XLEN'(4);
      if (imem_resp_valid && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - CW'(1);
    end
  end

  // The tag FIFO is never flushed: dropped responses still pop their tag.
  fetch_fifo #(.T_ENTRY(logic [XLEN-1:0]), .DEPTH(DEPTH)) u_tag_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_req_fire),
    .i_push_data (r_pc),
    .i_pop       (imem_resp_valid),
    .i_flush     (1'b0),
    .o_head      (w_tag_head),
    .o_count     (w_inflight),
    .o_full      (w_tag_full),
    .o_empty     (w_tag_empty)
  );

  fetch_fifo #(.T_ENTRY(fetch_entry_t), .DEPTH(DEPTH)) u_instr_q (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_q_push),
    .i_push_data (w_q_in),
    .i_pop       (w_q_pop),
    .i_flush     (redirect_valid),
    .o_head      (w_q_head),
    .o_count     (w_occ),
    .o_full      (w_q_full),
    .o_empty     (w_q_empty)
  );

  assign instr_valid = rst & ~w_q_empty;
  assign instr       = w_q_head.instr;
  assign instr_pc    = w_q_head.pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(w_q_push && w_q_full));
      assert (!(w_req_fire && w_tag_full));
      assert (!(imem_resp_valid && w_tag_empty));
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: an in-order variable-latency memory plus a queue-level
// reference model, directed redirect/reset scenarios and a randomized soak.
module tb_fetch_unit;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc)
  );

  typedef struct { logic [31:0] addr; int due; bit stale; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ins_t;

  req_t        pend[$];
  ins_t        expq[$];
  logic [31:0] m_pc;
  int          cyc;
  int          n_cmp;
  int          n_bad;
  int          lat_min, lat_max, req_rdy_pct, ins_rdy_pct, redir_pct;
  bit          force_redir;
  logic [31:0] force_pc;
  logic [31:0] pop_pc_q[$];
  logic [31:0] pop_cyc_q[$];
  logic [31:0] acc_addr_q[$];
  int          first_req_cyc;
  int          first_iv_cyc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
  endfunction

  function automatic logic [31:0] at_or(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: drive after the edge, check at negedge, advance the model at the edge.
  task automatic cycle();
    bit   exp_req_v, exp_iv, stale_any, req_fire, pop, resp;
    int   lat, due;
    if (force_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = force_pc;
    end else begin
      redirect_valid = rst && ($urandom_range(99) < redir_pct);
      redirect_pc    = $urandom;
    end
    force_redir = 1'b0;
    resp = rst && (pend.size() > 0) && (pend[0].due <= cyc);
    imem_resp_valid = resp;
    imem_resp_data  = resp ? mem_word(pend[0].addr) : $urandom;
    imem_req_ready  = ($urandom_range(99) < req_rdy_pct);
    instr_ready     = ($urandom_range(99) < ins_rdy_pct);

    @(negedge clk);
    stale_any = 1'b0;
    foreach (pend[i]) if (pend[i].stale) stale_any = 1'b1;
    exp_req_v = rst && !redirect_valid && (pend.size() + expq.size() < DEPTH) && !stale_any;
    exp_iv    = rst && (expq.size() > 0);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_req_v));
    if (exp_req_v) chk("req_addr", imem_req_addr, m_pc);
    chk("instr_valid", 32'(instr_valid), 32'(exp_iv));
    if (exp_iv) begin
      chk("instr_pc", instr_pc, expq[0].pc);
      chk("instr", instr, expq[0].data);
    end
    req_fire = exp_req_v && imem_req_ready;
    pop      = exp_iv && instr_ready;
    if (imem_req_valid && first_req_cyc < 0) first_req_cyc = cyc;
    if (instr_valid && first_iv_cyc < 0) first_iv_cyc = cyc;
    if (instr_valid && instr_ready) begin
      pop_pc_q.push_back(instr_pc);
      pop_cyc_q.push_back(32'(cyc));
    end
    if (imem_req_valid && imem_req_ready) acc_addr_q.push_back(imem_req_addr);

    @(posedge clk);
    if (!rst) begin
      pend.delete();
      expq.delete();
      m_pc = RESET_PC;
    end else begin
      if (pop) expq.delete(0);
      if (resp) begin
        if (!pend[0].stale && !redirect_valid)
          expq.push_back('{pend[0].addr, mem_word(pend[0].addr)});
        pend.delete(0);
      end
      if (redirect_valid) begin
        expq.delete();
        foreach (pend[i]) pend[i].stale = 1'b1;
        m_pc = {redirect_pc[31:2], 2'b00};
      end else if (req_fire) begin
        lat = $urandom_range(lat_max, lat_min);
        due = cyc + lat;
        if (pend.size() > 0 && pend[pend.size()-1].due >= due) due = pend[pend.size()-1].due + 1;
        pend.push_back('{m_pc, due, 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic set_knobs(input int lmin, input int lmax, input int rq, input int ir, input int rd);
    lat_min = lmin; lat_max = lmax; req_rdy_pct = rq; ins_rdy_pct = ir; redir_pct = rd;
  endtask

  initial begin
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = '0; instr_ready = 1'b0;
    n_cmp = 0; n_bad = 0; cyc = 0; m_pc = RESET_PC; force_redir = 1'b0; force_pc = '0;
    first_req_cyc = -1; first_iv_cyc = -1;
    set_knobs(1, 1, 100, 100, 0);
    @(posedge clk); #1;
    repeat (2) cycle();

    // Streaming from reset with a 1-cycle memory.
    rst = 1'b1;
    repeat (12) cycle();
    chk("first_iv_latency", 32'(first_iv_cyc - first_req_cyc), 32'd2);
    for (int i = 0; i < 4; i++) chk("stream_pc", at_or(pop_pc_q, i), 32'(4 * i));
    chk("stream_tput", at_or(pop_cyc_q, 3) - at_or(pop_cyc_q, 0), 32'd3);

    // Decode stalled from reset: queue fills to DEPTH, then drains in order.
    rst = 1'b0; cycle(); rst = 1'b1;
    set_knobs(1, 1, 100, 0, 0);
    pop_pc_q.delete();
    repeat (10) cycle();
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    chk("stall_head_pc", instr_pc, 32'h0);
    chk("stall_no_pop", 32'(pop_pc_q.size()), 32'd0);
    ins_rdy_pct = 100;
    repeat (8) cycle();
    for (int i = 0; i < 5; i++) chk("drain_pc", at_or(pop_pc_q, i), 32'(4 * i));

    // 3-cycle memory: redirect with two requests outstanding.
    set_knobs(3, 3, 100, 100, 0);
    for (int i = 0; i < 20; i++) begin
      if (pend.size() == 2) break;
      cycle();
    end
    force_redir = 1'b1; force_pc = 32'h100;
    cycle();
    pop_pc_q.delete();
    repeat (12) cycle();
    chk("redir_first_pc", at_or(pop_pc_q, 0), 32'h100);
    chk("redir_second_pc", at_or(pop_pc_q, 1), 32'h104);

    // Redirect coinciding with a response and a decode handshake.
    set_knobs(1, 1, 100, 100, 0);
    repeat (4) cycle();
    for (int i = 0; i < 20; i++) begin
      if (expq.size() > 0 && pend.size() > 0 && pend[0].due <= cyc) break;
      cycle();
    end
    force_redir = 1'b1; force_pc = 32'h200;
    pop_pc_q.delete();
    cycle();
    chk("redir_hs_pops", 32'(pop_pc_q.size()), 32'd1);
    chk("redir_hs_empty", 32'(instr_valid), 32'd0);

    // Misaligned redirect near the top of the address space wraps to zero.
    force_redir = 1'b1; force_pc = 32'hFFFF_FFFE;
    cycle();
    acc_addr_q.delete();
    repeat (6) cycle();
    chk("wrap_addr0", at_or(acc_addr_q, 0), 32'hFFFF_FFFC);
    chk("wrap_addr1", at_or(acc_addr_q, 1), 32'h0);
    chk("wrap_addr2", at_or(acc_addr_q, 2), 32'h4);

    // Reset mid-stream with a partly full queue.
    ins_rdy_pct = 0;
    repeat (3) cycle();
    chk("rst_pre_iv", 32'(instr_valid), 32'd1);
    rst = 1'b0;
    cycle();
    chk("rst_iv", 32'(instr_valid), 32'd0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    rst = 1'b1; ins_rdy_pct = 100;
    acc_addr_q.delete(); pop_pc_q.delete();
    repeat (8) cycle();
    chk("rst_restart_addr", at_or(acc_addr_q, 0), RESET_PC);
    chk("rst_restart_pc0", at_or(pop_pc_q, 0), RESET_PC);
    chk("rst_restart_pc1", at_or(pop_pc_q, 1), RESET_PC + 32'd4);

    // Randomized soak: latency, backpressure, redirects and occasional reset.
    for (int blk = 0; blk < 30; blk++) begin
      int lmin;
      lmin = $urandom_range(2, 1);
      set_knobs(lmin, $urandom_range(5, lmin), $urandom_range(100, 30),
                $urandom_range(100, 20), $urandom_range(8, 0));
      for (int i = 0; i < 100; i++) begin
        rst = ($urandom_range(199) != 0);
        cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
